// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side bundle for the register-bank write arbiter.
// Three requesters share one set of packed valid/addr/data lines; the
// arbiter answers with a one-hot ready vector.
interface regfile_wr_arbiter_if;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;

  // writeback sources drive requests and observe the grant
  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  // the arbiter consumes requests and drives the grant
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the 32x32 register bank.
// After reset it sweeps every register (INIT_ADDR gets INIT_VAL, the rest 0),
// then shares the bank's single write port among three requesters using
// round-robin arbitration over a valid/ready handshake. The bank's own reset
// is tied off, so this sweep is what gives the registers known contents.
module regfile_wr_arbiter #(
  parameter logic [4:0]  INIT_ADDR = 5'd5,
  parameter logic [31:0] INIT_VAL  = 32'h000FFFAF
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  hold,
  regfile_wr_arbiter_if.slave   req,
  output logic                  WE3,
  output logic [4:0]            A3,
  output logic [31:0]           WD3,
  output logic                  init_done
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  cnt_r;
  logic [4:0]  cnt_s;
  logic [1:0]  ptr_r;
  logic [1:0]  ptr_s;
  logic        we_r;
  logic        we_s;
  logic [4:0]  a3_r;
  logic [4:0]  a3_s;
  logic [31:0] wd3_r;
  logic [31:0] wd3_s;
  logic        done_r;
  logic        done_s;

  logic [2:0]  grant_s;
  logic [1:0]  gidx_s;

  // Round-robin pick: first valid requester searching ptr, ptr+1, ptr+2 (mod 3).
  // A pointer value of 3 never occurs; it falls back to the ptr=0 order.
  function automatic logic [2:0] rr_grant(input logic [2:0] v, input logic [1:0] p);
    logic [2:0] g;
    case (p)
      2'd1: begin
        if (v[1])      g = 3'b010;
        else if (v[2]) g = 3'b100;
        else if (v[0]) g = 3'b001;
        else           g = 3'b000;
      end
      2'd2: begin
        if (v[2])      g = 3'b100;
        else if (v[0]) g = 3'b001;
        else if (v[1]) g = 3'b010;
        else           g = 3'b000;
      end
      default: begin
        if (v[0])      g = 3'b001;
        else if (v[1]) g = 3'b010;
        else if (v[2]) g = 3'b100;
        else           g = 3'b000;
      end
    endcase
    return g;
  endfunction

  // One-hot grant to requester index.
  function automatic logic [1:0] onehot_idx(input logic [2:0] g);
    logic [1:0] i;
    case (g)
      3'b010:  i = 2'd1;
      3'b100:  i = 2'd2;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

  // Pointer moves to the requester after the one just served.
  function automatic logic [1:0] ptr_after(input logic [1:0] i);
    logic [1:0] n;
    case (i)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Address lane of the selected requester.
  function automatic logic [4:0] sel_addr(input logic [14:0] a, input logic [1:0] i);
    logic [4:0] r;
    case (i)
      2'd1:    r = a[9:5];
      2'd2:    r = a[14:10];
      default: r = a[4:0];
    endcase
    return r;
  endfunction

  // Data lane of the selected requester.
  function automatic logic [31:0] sel_data(input logic [95:0] d, input logic [1:0] i);
    logic [31:0] r;
    case (i)
      2'd1:    r = d[63:32];
      2'd2:    r = d[95:64];
      default: r = d[31:0];
    endcase
    return r;
  endfunction

  // Grant decode: only in RUN and not stalled; never looks at addr/data.
  always_comb begin
    grant_s = 3'b000;
    if ((state_r == ST_RUN) && !hold) begin
      grant_s = rr_grant(req.req_valid, ptr_r);
    end else begin
      grant_s = 3'b000;
    end
  end

  assign gidx_s        = onehot_idx(grant_s);
  assign req.req_ready = grant_s;

  // Next-state and next-output logic for the INIT sweep and RUN arbitration.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ptr_s   = ptr_r;
    we_s    = 1'b0;
    a3_s    = a3_r;
    wd3_s   = wd3_r;
    done_s  = done_r;
    case (state_r)
      ST_INIT: begin
        we_s  = 1'b1;
        a3_s  = cnt_r;
        wd3_s = (cnt_r == INIT_ADDR) ? INIT_VAL : 32'h0000_0000;
        cnt_s = cnt_r + 5'd1;
        if (cnt_r == 5'd31) begin
          state_s = ST_RUN;
          done_s  = 1'b1;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (grant_s != 3'b000) begin
          we_s  = 1'b1;
          a3_s  = sel_addr(req.req_addr, gidx_s);
          wd3_s = sel_data(req.req_data, gidx_s);
          ptr_s = ptr_after(gidx_s);
        end else begin
          we_s  = 1'b0;
        end
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = 5'd0;
        ptr_s   = 2'd0;
        we_s    = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered bank-side outputs.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r <= ST_INIT;
      cnt_r   <= 5'd0;
      ptr_r   <= 2'd0;
      we_r    <= 1'b0;
      a3_r    <= 5'd0;
      wd3_r   <= 32'h0000_0000;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ptr_r   <= ptr_s;
      we_r    <= we_s;
      a3_r    <= a3_s;
      wd3_r   <= wd3_s;
      done_r  <= done_s;
    end
  end

  assign WE3       = we_r;
  assign A3        = a3_r;
  assign WD3       = wd3_r;
  assign init_done = done_r;

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port controller for the 32x32 register bank. After reset it runs an initialisation sweep that writes every register (address `INIT_ADDR` gets `INIT_VAL`, all others 0). It then shares the bank's single write port (WE3/A3/WD3) among three requesters with round-robin arbitration and a valid/ready handshake. It sits between the writeback sources (ALU, load unit, debug/host interface) and the register bank, whose own reset input is tied inactive in designs using this block.

## Interface
- `INIT_ADDR`, 5'd5, register address loaded with `INIT_VAL` during the init sweep
- `INIT_VAL`, 32'h000FFFAF, init value for `INIT_ADDR`; all other addresses initialise to 0
- `CLK`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `hold`  in  1  RUN-state stall; when 1, no grants are issued
- `req_valid`  in  3  per-requester write request; bit i = requester i
- `req_addr`  in  15  packed addresses; [5i+4:5i] = requester i
- `req_data`  in  96  packed data; [32i+31:32i] = requester i
- `req_ready`  out  3  one-hot grant, combinational; transfer when valid[i] & ready[i]
- `WE3`  out  1  registered write enable to the bank
- `A3`  out  5  registered write address to the bank
- `WD3`  out  32  registered write data to the bank
- `init_done`  out  1  registered; 1 once the init sweep has completed

## Operation
- FSM has two states: INIT and RUN. Reset forces INIT with `cnt`=0 and round-robin pointer `ptr`=0.
- INIT:
  - every rising edge loads WE3<=1, A3<=cnt, WD3<=(cnt==INIT_ADDR ? INIT_VAL : 0), then cnt<=cnt+1.
  - on the edge that issues cnt=31, the FSM moves to RUN and init_done<=1.
  - `req_ready` is 0 throughout INIT; `hold` is ignored.
- RUN, grant logic:
  - when `hold`=0 and any `req_valid` is set, grant exactly one requester.
  - the grant goes to the first valid requester searching ptr, ptr+1, ptr+2 (mod 3).
  - req_ready = one-hot of the granted requester, otherwise 000.
- RUN, on a granted edge: WE3<=1, A3<=req_addr[g], WD3<=req_data[g], ptr<=(g+1) mod 3.
- RUN, no grant (no valid requests, or hold=1): WE3<=0; A3/WD3 hold their values; ptr unchanged.
- Requester rules:
  - a requester keeps valid asserted with addr/data stable until it sees ready.
  - a requester may deassert valid only after the transfer.
  - the arbiter does not check this.
- All addresses, including 0, are written as given; there is no hardwired-zero filtering.
- Simultaneous requests to the same address from different requesters are serialised in grant order; the last granted wins.
- The FSM never returns to INIT except via reset.

## Timing
- Reset values, applied immediately (asynchronous): WE3=0, A3=0, WD3=0, init_done=0, req_ready=000, state=INIT, cnt=0, ptr=0.
- First rising edge with reset high issues the write to address 0. The sweep takes exactly 32 edges; address 31 and init_done=1 appear after edge 32.
- Write latency: a handshake in cycle k puts WE3/A3/WD3 at the bank after edge k+1, and the bank stores the value at edge k+2.
- Throughput is one write per cycle when any request is pending.
- Starvation bound: a continuously valid requester is granted within 3 RUN cycles in which hold=0.
- Reset mid-sweep or mid-RUN: outputs clear at once, and a full 32-cycle sweep restarts after release. A request pending when reset asserts is not written and must be re-presented.
- req_ready depends combinationally on req_valid, hold, state and ptr only; there is no path from req_addr/req_data.

## Test plan
- Reset release, no requests: 32 consecutive cycles of WE3=1 with A3=0..31. WD3=0x000FFFAF at A3=5 and 0 elsewhere. init_done=1 from edge 32, then WE3=0.
- All three valid continuously from RUN start, each with distinct addr/data: grants cycle 001,010,100,001,…. The bank sees writes in order req0, req1, req2, req0, one per cycle.
- Only req1 valid (addr 7, data 0xDEADBEEF) during INIT: req_ready stays 000 until RUN. Granted on the first RUN cycle; WE3=1, A3=7, WD3=0xDEADBEEF one edge later.
- hold=1 for 4 cycles with req0 and req2 valid: req_ready=000 and WE3=0 for those cycles. After hold drops, grants resume from the current ptr.
- Reset asserted during RUN while req2 holds valid: WE3, A3, WD3, init_done and req_ready go to 0 before the next edge. A full sweep follows release; req2 is served only after init_done=1.
- req0 and req1 both target address 3 in the same cycle with data 0x11 / 0x22: two consecutive writes, 0x11 then 0x22. Reading address 3 from the bank afterwards returns 0x22.
